// File: rtl/clz_share_arb.sv
// Shares one fixed-latency CLZ pipeline among N_REQ requesters: round-robin issue,
// a tag pipe that tracks each issue through the datapath, and routed responses.
module clz_share_arb #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 128,
  parameter int CLZ_W    = 8,
  parameter int LATENCY  = 8,
  parameter int MAX_INFL = 4
) (
  input  logic                    i_CLK,
  input  logic                    i_RSTn,
  input  logic [N_REQ-1:0]        i_REQ_VALID,
  input  logic [N_REQ*DATA_W-1:0] i_REQ_DATA,
  output logic [N_REQ-1:0]        o_REQ_READY,
  output logic                    o_CLZ_ENB,
  output logic                    o_CLZ_VALID,
  output logic [DATA_W-1:0]       o_CLZ_DATA,
  input  logic                    i_CLZ_VALID,
  input  logic [CLZ_W-1:0]        i_CLZ_RESULT,
  input  logic [DATA_W-1:0]       i_CLZ_DATA,
  output logic [N_REQ-1:0]        o_RSP_VALID,
  output logic [CLZ_W-1:0]        o_RSP_CLZ,
  output logic [DATA_W-1:0]       o_RSP_DATA,
  input  logic [N_REQ-1:0]        i_RSP_READY,
  output logic                    o_IDLE
);

  localparam int ID_W   = $clog2(N_REQ);
  localparam int STAGES = LATENCY + 1;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [ID_W-1:0]   rr_q, rr_d;
  tag_t              tag_q [STAGES];
  logic [3:0]        infl_q [N_REQ];
  logic [3:0]        infl_d [N_REQ];

  logic [DATA_W-1:0] req_word [N_REQ];
  logic [N_REQ-1:0]  elig;
  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   winner;
  logic              found;
  logic              issue;
  logic              accept;
  logic              all_zero;
  int                idx;
  tag_t              head;

  assign head      = tag_q[STAGES-1];
  assign o_CLZ_ENB = ~(i_CLZ_VALID & ~i_RSP_READY[head.id]);
  assign accept    = i_CLZ_VALID & head.vld & i_RSP_READY[head.id];

  for (genvar g = 0; g < N_REQ; g++) begin : g_req
    assign req_word[g] = i_REQ_DATA[g*DATA_W +: DATA_W];
    assign elig[g]     = i_REQ_VALID[g] && (infl_q[g] < 4'(MAX_INFL));
  end

  // Search from the rotating pointer; gating with reset keeps READY low while held.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    grant  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && elig[ID_W'(idx)]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
    if (found && o_CLZ_ENB && i_RSTn) grant[winner] = 1'b1;
  end

  assign issue       = |grant;
  assign o_REQ_READY = grant;
  assign o_CLZ_VALID = issue;
  assign o_CLZ_DATA  = issue ? req_word[winner] : '0;

  always_comb begin
    rr_d = rr_q;
    if (issue) rr_d = (int'(winner) == N_REQ-1) ? '0 : winner + ID_W'(1);
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      infl_d[i] = infl_q[i];
      if (grant[i] && !(accept && head.id == ID_W'(i)))
        infl_d[i] = infl_q[i] + 4'd1;
      else if (!grant[i] && accept && head.id == ID_W'(i) && infl_q[i] != 4'd0)
        infl_d[i] = infl_q[i] - 4'd1;
    end
  end

  always_comb begin
    o_RSP_VALID = '0;
    if (i_CLZ_VALID && head.vld) o_RSP_VALID[head.id] = 1'b1;
  end

  assign o_RSP_CLZ  = i_CLZ_RESULT;
  assign o_RSP_DATA = i_CLZ_DATA;

  always_comb begin
    all_zero = 1'b1;
    for (int i = 0; i < N_REQ; i++)
      if (infl_q[i] != 4'd0) all_zero = 1'b0;
  end

  assign o_IDLE = all_zero & ~|i_REQ_VALID;

  // Tag pipe advances only with the datapath so the head always names the CLZ output owner.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      rr_q <= '0;
      for (int s = 0; s < STAGES; s++) tag_q[s] <= '0;
      for (int i = 0; i < N_REQ; i++) infl_q[i] <= '0;
    end else begin
      rr_q <= rr_d;
      for (int i = 0; i < N_REQ; i++) infl_q[i] <= infl_d[i];
      if (o_CLZ_ENB) begin
        tag_q[0] <= {issue, winner};
        for (int s = 1; s < STAGES; s++) tag_q[s] <= tag_q[s-1];
      end
    end
  end

endmodule

// File: tb/tb_clz_share_arb.sv
// Directed bench for clz_share_arb with a behavioural 9-edge CLZ pipeline model.
module tb_clz_share_arb;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rstN;
  logic [N-1:0]   reqValid;
  logic [N*128-1:0] reqData;
  logic [N-1:0]   reqReady;
  logic           clzEnb;
  logic           clzValidOut;
  logic [127:0]   clzDataOut;
  logic           clzValidIn;
  logic [7:0]     clzResultIn;
  logic [127:0]   clzDataIn;
  logic [N-1:0]   rspValid;
  logic [7:0]     rspClz;
  logic [127:0]   rspData;
  logic [N-1:0]   rspReady;
  logic           idle;

  int total = 0;
  int passed = 0;

  logic [8:0]   mV;
  logic [127:0] mD [9];
  logic [7:0]   mR [9];

  always #5 clk = ~clk;

  clz_share_arb dut (
    .i_CLK(clk), .i_RSTn(rstN),
    .i_REQ_VALID(reqValid), .i_REQ_DATA(reqData), .o_REQ_READY(reqReady),
    .o_CLZ_ENB(clzEnb), .o_CLZ_VALID(clzValidOut), .o_CLZ_DATA(clzDataOut),
    .i_CLZ_VALID(clzValidIn), .i_CLZ_RESULT(clzResultIn), .i_CLZ_DATA(clzDataIn),
    .o_RSP_VALID(rspValid), .o_RSP_CLZ(rspClz), .o_RSP_DATA(rspData),
    .i_RSP_READY(rspReady), .o_IDLE(idle)
  );

  function automatic logic [7:0] clzOf(input logic [127:0] w);
    for (int b = 127; b >= 0; b--) if (w[b]) return 8'(127 - b);
    return 8'd128;
  endfunction

  // Stand-in for the CLZ instance: registers its input, 9 enabled edges to output.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mV <= '0;
      for (int s = 0; s < 9; s++) begin mD[s] <= '0; mR[s] <= '0; end
    end else if (clzEnb) begin
      mV    <= {mV[7:0], clzValidOut};
      mD[0] <= clzDataOut;
      mR[0] <= clzOf(clzDataOut);
      for (int s = 1; s < 9; s++) begin mD[s] <= mD[s-1]; mR[s] <= mR[s-1]; end
    end
  end

  assign clzValidIn  = mV[8];
  assign clzDataIn   = mD[8];
  assign clzResultIn = mR[8];

  always @(negedge clk) begin
    if (rstN && ((clzValidIn && rspValid == '0) || (!clzValidIn && rspValid != '0))) begin
      total++;
      $display("[TB] FAIL head_align: rspValid=%b clzValid=%b", rspValid, clzValidIn);
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setWord(input int r, input logic [127:0] w);
    reqData[r*128 +: 128] = w;
  endtask

  task automatic doReset;
    rstN = 1'b0;
    reqValid = '0;
    rspReady = '1;
    repeat (2) tick;
    rstN = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    rstN = 1'b0;
    reqValid = 4'hF;
    reqData = '0;
    rspReady = '1;
    repeat (2) tick;
    total++;
    if (reqReady !== 4'b0 || clzValidOut !== 1'b0 || clzDataOut !== 128'd0)
      $display("[TB] FAIL reset_issue: ready=%b clzValid=%b clzData=%h required 0/0/0", reqReady, clzValidOut, clzDataOut);
    else passed++;
    reqValid = '0;
    #1;
    total++;
    if (rspValid !== 4'b0 || rspClz !== 8'd0 || rspData !== 128'd0 || idle !== 1'b1 || clzEnb !== 1'b1)
      $display("[TB] FAIL reset_rsp: rspValid=%b clz=%0d data=%h idle=%b enb=%b required 0/0/0/1/1", rspValid, rspClz, rspData, idle, clzEnb);
    else passed++;
    rstN = 1'b1;
    tick;
  endtask

  task automatic test_single;
    logic [127:0] w;
    int edges;
    w = 128'h0000_0000_0000_0001_0000_0000_0000_0000;
    reqValid = 4'b0100;
    setWord(2, w);
    #1;
    total++;
    if (reqReady !== 4'b0100 || clzValidOut !== 1'b1 || clzDataOut !== w)
      $display("[TB] FAIL single_grant: ready=%b clzValid=%b data=%h required 0100/1/%h", reqReady, clzValidOut, clzDataOut, w);
    else passed++;
    tick;
    reqValid = '0;
    edges = 1;
    #1;
    while (rspValid == '0 && edges < 20) begin tick; edges++; #1; end
    total++;
    if (edges != 9 || rspValid !== 4'b0100 || rspClz !== 8'd63 || rspData !== w)
      $display("[TB] FAIL single_rsp: edges=%0d valid=%b clz=%0d data=%h required 9/0100/63/%h", edges, rspValid, rspClz, rspData, w);
    else passed++;
    tick;
    total++;
    if (rspValid !== 4'b0 || idle !== 1'b1)
      $display("[TB] FAIL single_done: valid=%b idle=%b required 0/1", rspValid, idle);
    else passed++;
  endtask

  task automatic test_round_robin;
    logic [127:0] words [4];
    logic [7:0]   expClz [4];
    int q [$];
    int exp, nRsp;
    logic [N-1:0] expGrant;
    words[0] = 128'h1 << 127; expClz[0] = 8'd0;
    words[1] = 128'h1 << 100; expClz[1] = 8'd27;
    words[2] = 128'h1 << 64;  expClz[2] = 8'd63;
    words[3] = 128'h1;        expClz[3] = 8'd127;
    doReset;
    for (int r = 0; r < 4; r++) setWord(r, words[r]);
    reqValid = 4'hF;
    nRsp = 0;
    for (int c = 0; c < 36; c++) begin
      if (c == 16) reqValid = '0;
      #1;
      if (c < 16) begin
        expGrant = 4'b0001 << (c % 4);
        total++;
        if (reqReady !== expGrant)
          $display("[TB] FAIL rr_grant c%0d: ready=%b required %b", c, reqReady, expGrant);
        else passed++;
        q.push_back(c % 4);
      end
      if (rspValid != '0) begin
        total++;
        nRsp++;
        if (q.size() == 0)
          $display("[TB] FAIL rr_rsp c%0d: valid=%b required no response", c, rspValid);
        else begin
          exp = q.pop_front();
          if (rspValid !== (4'b0001 << exp) || rspClz !== expClz[exp] || rspData !== words[exp])
            $display("[TB] FAIL rr_rsp c%0d: valid=%b clz=%0d required %b/%0d", c, rspValid, rspClz, 4'b0001 << exp, expClz[exp]);
          else passed++;
        end
      end
      tick;
    end
    total++;
    if (nRsp != 16 || idle !== 1'b1)
      $display("[TB] FAIL rr_drain: responses=%0d idle=%b required 16/1", nRsp, idle);
    else passed++;
  endtask

  task automatic test_backpressure;
    logic [127:0] w;
    int nRsp;
    doReset;
    rspReady = 4'b1110;
    reqValid = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      w = 128'h1 << (117 - c);
      setWord(0, w);
      #1;
      total++;
      if (reqReady !== 4'b0001)
        $display("[TB] FAIL bp_grant c%0d: ready=%b required 0001", c, reqReady);
      else passed++;
      tick;
    end
    for (int c = 4; c < 9; c++) begin
      #1;
      total++;
      if (reqReady !== 4'b0)
        $display("[TB] FAIL bp_limit c%0d: ready=%b required 0000", c, reqReady);
      else passed++;
      tick;
    end
    w = 128'h1 << 117;
    for (int c = 9; c < 13; c++) begin
      #1;
      total++;
      if (clzEnb !== 1'b0 || rspValid !== 4'b0001 || rspClz !== 8'd10 || rspData !== w || reqReady !== 4'b0)
        $display("[TB] FAIL bp_stall c%0d: enb=%b valid=%b clz=%0d ready=%b required 0/0001/10/0000", c, clzEnb, rspValid, rspClz, reqReady);
      else passed++;
      tick;
    end
    rspReady[0] = 1'b1;
    #1;
    total++;
    if (clzEnb !== 1'b1 || rspValid !== 4'b0001 || reqReady !== 4'b0)
      $display("[TB] FAIL bp_accept: enb=%b valid=%b ready=%b required 1/0001/0000", clzEnb, rspValid, reqReady);
    else passed++;
    tick;
    rspReady[0] = 1'b0;
    #1;
    w = 128'h1 << 116;
    total++;
    if (clzEnb !== 1'b0 || rspClz !== 8'd11 || rspData !== w || reqReady !== 4'b0)
      $display("[TB] FAIL bp_one_accept: enb=%b clz=%0d ready=%b required 0/11/0000", clzEnb, rspClz, reqReady);
    else passed++;
    tick;
    rspReady[0] = 1'b1;
    setWord(0, 128'h1 << 113);
    #1;
    total++;
    if (reqReady !== 4'b0001 || rspValid !== 4'b0001 || rspClz !== 8'd11)
      $display("[TB] FAIL bp_regrant: ready=%b valid=%b clz=%0d required 0001/0001/11", reqReady, rspValid, rspClz);
    else passed++;
    tick;
    reqValid = '0;
    nRsp = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (rspValid != '0) nRsp++;
      tick;
    end
    total++;
    if (nRsp != 3 || idle !== 1'b1)
      $display("[TB] FAIL bp_drain: responses=%0d idle=%b required 3/1", nRsp, idle);
    else passed++;
  endtask

  task automatic test_boundary;
    logic [127:0] top;
    int nRsp;
    top = 128'h1 << 127;
    doReset;
    reqValid = 4'b0010;
    setWord(1, 128'd0);
    #1;
    total++;
    if (reqReady !== 4'b0010)
      $display("[TB] FAIL bnd_grant1: ready=%b required 0010", reqReady);
    else passed++;
    tick;
    reqValid = 4'b1000;
    setWord(3, top);
    #1;
    total++;
    if (reqReady !== 4'b1000)
      $display("[TB] FAIL bnd_grant3: ready=%b required 1000", reqReady);
    else passed++;
    tick;
    reqValid = '0;
    nRsp = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (rspValid != '0) begin
        total++;
        if (nRsp == 0 && (rspValid !== 4'b0010 || rspClz !== 8'd128 || rspData !== 128'd0))
          $display("[TB] FAIL bnd_zero: valid=%b clz=%0d required 0010/128", rspValid, rspClz);
        else if (nRsp == 1 && (rspValid !== 4'b1000 || rspClz !== 8'd0 || rspData !== top))
          $display("[TB] FAIL bnd_top: valid=%b clz=%0d required 1000/0", rspValid, rspClz);
        else if (nRsp > 1)
          $display("[TB] FAIL bnd_extra: valid=%b required none", rspValid);
        else passed++;
        nRsp++;
      end
      tick;
    end
    total++;
    if (nRsp != 2)
      $display("[TB] FAIL bnd_count: responses=%0d required 2", nRsp);
    else passed++;
  endtask

  task automatic test_reset_midflight;
    int edges;
    bit stray;
    doReset;
    setWord(0, 128'h1 << 127);
    setWord(1, 128'h1 << 100);
    setWord(2, 128'h1 << 64);
    setWord(3, 128'h1);
    reqValid = 4'hF;
    repeat (5) tick;
    rstN = 1'b0;
    #1;
    total++;
    if (reqReady !== 4'b0 || clzValidOut !== 1'b0 || clzDataOut !== 128'd0 || rspValid !== 4'b0 || clzEnb !== 1'b1 || idle !== 1'b0)
      $display("[TB] FAIL midrst_out: ready=%b clzValid=%b rspValid=%b enb=%b idle=%b required 0/0/0/1/0", reqReady, clzValidOut, rspValid, clzEnb, idle);
    else passed++;
    reqValid = '0;
    #1;
    total++;
    if (idle !== 1'b1)
      $display("[TB] FAIL midrst_idle: idle=%b required 1", idle);
    else passed++;
    repeat (2) tick;
    rstN = 1'b1;
    stray = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick;
      if (rspValid != '0) stray = 1'b1;
    end
    total++;
    if (stray)
      $display("[TB] FAIL midrst_stray: stray=%b required 0", stray);
    else passed++;
    reqValid = 4'b0010;
    #1;
    tick;
    reqValid = '0;
    edges = 1;
    #1;
    while (rspValid == '0 && edges < 20) begin tick; edges++; #1; end
    total++;
    if (edges != 9 || rspValid !== 4'b0010 || rspClz !== 8'd27)
      $display("[TB] FAIL midrst_next: edges=%0d valid=%b clz=%0d required 9/0010/27", edges, rspValid, rspClz);
    else passed++;
    tick;
  endtask

  task automatic test_grant_accept;
    doReset;
    reqValid = 4'b0010;
    setWord(1, 128'h1 << 90);
    repeat (2) begin
      #1;
      total++;
      if (reqReady !== 4'b0010)
        $display("[TB] FAIL ga_setup: ready=%b required 0010", reqReady);
      else passed++;
      tick;
    end
    reqValid = '0;
    repeat (7) tick;
    reqValid = 4'b0010;
    setWord(1, 128'h1 << 80);
    #1;
    total++;
    if (reqReady !== 4'b0010 || rspValid !== 4'b0010 || rspClz !== 8'd37)
      $display("[TB] FAIL ga_same: ready=%b valid=%b clz=%0d required 0010/0010/37", reqReady, rspValid, rspClz);
    else passed++;
    tick;
    reqValid = 4'b0110;
    setWord(2, 128'h1 << 70);
    #1;
    total++;
    if (reqReady !== 4'b0100 || dut.infl_q[1] !== 4'd2)
      $display("[TB] FAIL ga_after: ready=%b infl1=%0d required 0100/2", reqReady, dut.infl_q[1]);
    else passed++;
    tick;
    reqValid = '0;
    repeat (20) tick;
    total++;
    if (idle !== 1'b1)
      $display("[TB] FAIL ga_drain: idle=%b required 1", idle);
    else passed++;
  endtask

  initial begin
    rstN = 1'b0;
    reqValid = '0;
    reqData = '0;
    rspReady = '1;
    test_reset;
    test_single;
    test_round_robin;
    test_backpressure;
    test_boundary;
    test_reset_midflight;
    test_grant_accept;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/clz_share_arb.md
Name: clz_share_arb

Overview:
- Shares one CLZ pipeline (128-bit word in; 8-bit count plus delayed word out; fixed 8-enabled-cycle latency; global enb stall) among N_REQ requesters.
- Round-robin arbitration on the input side; a per-issue tag shift register that mirrors the pipeline latency.
- Routes each result back to its originator with valid/ready backpressure, and limits outstanding requests per requester.
- Sits between the log2 front-end requesters and the CLZ instance; owns that instance's enb and input valid.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 128, word width
- CLZ_W, 8, count width
- LATENCY, 8, CLZ pipeline depth in enabled cycles; must equal the datapath
- MAX_INFL, 4, max outstanding requests per requester (1..15)

Ports:
- i_CLK  in  1  clock
- i_RSTn  in  1  asynchronous active-low reset
- i_REQ_VALID  in  N_REQ  per-requester request valid
- i_REQ_DATA  in  N_REQ*DATA_W  per-requester word; slice i is requester i
- o_REQ_READY  out  N_REQ  one-hot grant; transfer when VALID&READY
- o_CLZ_ENB  out  1  pipeline enable to CLZ
- o_CLZ_VALID  out  1  input valid to CLZ
- o_CLZ_DATA  out  DATA_W  input word to CLZ
- i_CLZ_VALID  in  1  CLZ output valid
- i_CLZ_RESULT  in  CLZ_W  CLZ leading-zero count
- i_CLZ_DATA  in  DATA_W  CLZ delayed word
- o_RSP_VALID  out  N_REQ  one-hot result valid
- o_RSP_CLZ  out  CLZ_W  result count (shared bus)
- o_RSP_DATA  out  DATA_W  result word (shared bus)
- i_RSP_READY  in  N_REQ  per-requester result ready
- o_IDLE  out  1  no request in flight and no pending valid

Behaviour:
- Reset (async, active-low):
  - rr pointer = 0; tag pipe all invalid; in-flight counters = 0.
  - Outputs: o_REQ_READY=0, o_CLZ_VALID=0, o_CLZ_DATA=0, o_RSP_VALID=0, o_RSP_CLZ=0, o_RSP_DATA=0, o_IDLE=1, o_CLZ_ENB=1.
- Reset mid-operation:
  - CLZ shares the same reset; all in-flight work is discarded and counters return to 0.
  - No response is produced for requests lost to reset.
- Eligibility: requester i is eligible when i_REQ_VALID[i]=1 and infl[i] < MAX_INFL.
- Round-robin grant:
  - Search starts at rr_ptr and wraps modulo N_REQ; the first eligible requester wins.
  - Grant is issued only when o_CLZ_ENB=1.
  - o_REQ_READY = grant one-hot (combinational).
  - On grant, rr_ptr <= (winner+1) mod N_REQ; with no grant, rr_ptr holds.
- Issue:
  - o_CLZ_VALID = |grant; o_CLZ_DATA = winner's slice, 0 when no grant.
  - The CLZ registers its input on the same edge, so issue-to-result is LATENCY+1 edges of the same edge clock with enb=1 throughout.
- Tag pipe:
  - LATENCY+1 stages of {valid, id[clog2(N_REQ)-1:0]}; stage 0 loads {|grant, winner}.
  - Shifts only when o_CLZ_ENB=1; it stays aligned with i_CLZ_VALID. The head stage id routes the result.
  - A head-valid/i_CLZ_VALID mismatch is a configuration error; the bench asserts on it.
- Response:
  - o_RSP_VALID[head.id] = i_CLZ_VALID & head.valid; o_RSP_CLZ = i_CLZ_RESULT; o_RSP_DATA = i_CLZ_DATA (all combinational).
  - Accepted when i_RSP_READY[head.id]=1.
- Stall: o_CLZ_ENB = ~(i_CLZ_VALID & ~i_RSP_READY[head.id]).
  - While stalled: CLZ and tag pipe freeze, no grant, and o_RSP_* hold stable.
  - Only the head requester's ready matters.
- In-flight counters (width 4):
  - infl[i] +1 on grant to i; −1 on response accepted by i.
  - Both in the same cycle: unchanged.
  - A counter never exceeds MAX_INFL and never underflows.
- o_IDLE = all infl==0 & ~|i_REQ_VALID (combinational).
- Throughput: one issue per cycle when there is no backpressure.

Test Plan:
- Single request, requester 2, word 128'h0000_0000_0000_0001_0000_0000_0000_0000 -> o_REQ_READY=4'b0100 same cycle; o_RSP_VALID=4'b0100 exactly 9 edges later; o_RSP_CLZ=63; o_RSP_DATA equals the input word.
- All 4 requesters valid continuously, all ready=1 -> grants cycle 0,1,2,3,0,... one per cycle; responses return in the same order with matching CLZ; each infl settles at 2 or 3 and never exceeds 4.
- MAX_INFL=4, requester 0 only, i_RSP_READY[0]=0 -> 4 grants issued, then o_REQ_READY[0]=0 held.
  - When the first result reaches the head, o_CLZ_ENB=0 and the outputs stay frozen.
  - Raising ready for 1 cycle -> exactly one accept, infl[0] drops 4->3, and one new grant is allowed.
- Word all-zero -> o_RSP_CLZ=128; word 128'h8000...0 -> o_RSP_CLZ=0; both routed to the correct requester.
- Reset asserted with 5 requests in flight -> all outputs reach reset values immediately, o_IDLE=1 once requests drop, no stray o_RSP_VALID after release; the next request gets normal latency.
- Simultaneous grant and accept on requester 1 at infl=2 -> infl stays 2; rr_ptr advances to 2.
